// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester arbiter in front of a shared combinational LogicUnit
//
// Purpose:
//   Accepts one operation at a time from requester 0 or requester 1, drives it
//   into the external LogicUnit for one cycle, captures the result and returns
//   it on the winning requester's response port. One transaction in flight.
//
// Optional feature macro: LU_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration (pointer flips after each response)
//   undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req0_valid/req0_ready       requester 0 handshake
//   req0_A, req0_B, req0_S      requester 0 operands and logic-op select
//   req1_*                      same for requester 1
//   rsp0_valid/rsp0_ready       response 0 handshake
//   rsp0_data                   response 0 result
//   rsp1_*                      same for requester 1
//   lu_A, lu_B, lu_S            registered drive into the shared LogicUnit
//   lu_out                      LogicUnit output (combinational)
//   busy                        high while a transaction is in flight
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [1:0]       req0_S,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [1:0]       req1_S,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] lu_A,
  output logic [WIDTH-1:0] lu_B,
  output logic [1:0]       lu_S,
  input  logic [WIDTH-1:0] lu_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   winId;     // requester owning the in-flight transaction
  logic   pickReq1;  // arbitration result while IDLE
  logic   accept;
  logic   rspDone;

`ifdef LU_ARB_ROUND_ROBIN_EN
  logic rrPtr;  // requester favoured when both are valid

  always_comb begin
    pickReq1 = 1'b0;
    if (req0_valid && req1_valid) begin
      pickReq1 = rrPtr;
    end else begin
      pickReq1 = !req0_valid;
    end
  end
`else
  always_comb begin
    pickReq1 = !req0_valid;
  end
`endif

  // Ready is gated by rst so nothing is offered while reset is held.
  assign req0_ready = !rst && (state == IDLE) && !pickReq1 && req0_valid;
  assign req1_ready = !rst && (state == IDLE) &&  pickReq1 && req1_valid;
  assign accept     = req0_ready || req1_ready;

  // Only the winner's port can be valid, so a ready on the other port is inert.
  assign rspDone = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      winId      <= 1'b0;
      lu_A       <= '0;
      lu_B       <= '0;
      lu_S       <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      busy       <= 1'b0;
`ifdef LU_ARB_ROUND_ROBIN_EN
      rrPtr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Operands go straight into the LogicUnit drive registers; they
          // then hold until the next accept, so lu_* never follow req inputs.
          if (accept) begin
            winId <= pickReq1;
            lu_A  <= pickReq1 ? req1_A : req0_A;
            lu_B  <= pickReq1 ? req1_B : req0_B;
            lu_S  <= pickReq1 ? req1_S : req0_S;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (winId) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= lu_out;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= lu_out;
          end
          state <= RESP;
        end
        RESP: begin
          if (rspDone) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef LU_ARB_ROUND_ROBIN_EN
            rrPtr      <= ~winId;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0]  req0_S, req1_S;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] lu_A, lu_B, lu_out;
  logic [1:0]  lu_S;
  logic        busy;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  // LogicUnit stub
  assign lu_out = lu_A ^ lu_B ^ {30'b0, lu_S};

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_S(req0_S),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_S(req1_S),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .lu_A(lu_A), .lu_B(lu_B), .lu_S(lu_S), .lu_out(lu_out),
    .busy(busy)
  );

  // Reference arbitration: lastServed is the requester that completed most
  // recently (1 after reset, so requester 0 is favoured first).
  function automatic logic pickWinner(input logic v0, input logic v1, input logic lastServed);
`ifdef LU_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ~lastServed;
    return v0 ? 1'b0 : 1'b1;
`else
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic clearInputs;
    req0_valid = 0; req1_valid = 0;
    req0_A = '0; req0_B = '0; req0_S = '0;
    req1_A = '0; req1_B = '0; req1_S = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic doReset;
    @(negedge clk);
    clearInputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1;
    req0_valid = 1; req0_A = 32'hDEADBEEF; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    totalCnt++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0 got=%b exp=0", req0_ready); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passCnt++;
    totalCnt++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_rspvalid got=%b%b exp=00", rsp0_valid, rsp1_valid); else passCnt++;
    totalCnt++; if ({rsp0_data, rsp1_data} !== 64'h0) $display("FAIL reset_rspdata got=%h %h exp=0", rsp0_data, rsp1_data); else passCnt++;
    totalCnt++; if ({lu_A, lu_B, lu_S} !== 66'h0) $display("FAIL reset_lu got=%h %h %h exp=0", lu_A, lu_B, lu_S); else passCnt++;
    @(negedge clk);
    rst = 0;
    #1;
    totalCnt++; if (req0_ready !== 1'b1) $display("FAIL reset_release_ready0 got=%b exp=1", req0_ready); else passCnt++;
    clearInputs();
  endtask

  task automatic test_single_op;
    doReset();
    req0_valid = 1; req0_A = 32'h0000FFFF; req0_B = 32'h00000F0F; req0_S = 2'b01;
    rsp0_ready = 1;
    #1;
    totalCnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); else passCnt++;
    @(negedge clk);
    // accepted at the previous edge; scramble inputs to show they are not used
    req0_valid = 0; req0_A = $urandom; req0_B = $urandom; req0_S = 2'($urandom);
    #1;
    totalCnt++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passCnt++;
    totalCnt++; if (rsp0_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", rsp0_valid); else passCnt++;
    totalCnt++; if (lu_A !== 32'h0000FFFF) $display("FAIL single_luA got=%h exp=0000ffff", lu_A); else passCnt++;
    @(negedge clk); #1;
    totalCnt++; if (rsp0_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", rsp0_valid); else passCnt++;
    totalCnt++; if (rsp0_data !== 32'h0000F0F1) $display("FAIL single_data got=%h exp=0000f0f1", rsp0_data); else passCnt++;
    totalCnt++; if ({rsp1_valid, rsp1_data} !== 33'h0) $display("FAIL single_rsp1 got=%b %h exp=0 0", rsp1_valid, rsp1_data); else passCnt++;
    @(negedge clk); #1;
    totalCnt++; if ({busy, rsp0_valid} !== 2'b00) $display("FAIL single_done got=%b%b exp=00", busy, rsp0_valid); else passCnt++;
    clearInputs();
  endtask

  task automatic test_contention;
    logic        lastServed;
    logic        expPort;
    logic [31:0] gotData;
    int          got;
    doReset();
    lastServed = 1'b1;
    got = 0;
    req0_valid = 1; req0_A = 32'h1;
    req1_valid = 1; req1_A = 32'h2;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) begin
        expPort = pickWinner(1'b1, 1'b1, lastServed);
        gotData = rsp1_valid ? rsp1_data : rsp0_data;
        totalCnt++; if ({rsp1_valid, rsp0_valid} !== {expPort, ~expPort}) $display("FAIL contend_port n=%0d got=%b%b exp_port=%0d", got, rsp1_valid, rsp0_valid, expPort); else passCnt++;
        totalCnt++; if (gotData !== (expPort ? 32'h2 : 32'h1)) $display("FAIL contend_data n=%0d got=%h exp=%h", got, gotData, expPort ? 32'h2 : 32'h1); else passCnt++;
        lastServed = expPort;
        got++;
      end
    end
    totalCnt++; if (got !== 4) $display("FAIL contend_count got=%0d exp=4", got); else passCnt++;
    // requester 0 withdraws: requester 1 must be served next
    req0_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) begin
        got = 1;
        totalCnt++; if ({rsp1_valid, rsp1_data} !== {1'b1, 32'h2}) $display("FAIL contend_after_drop got=%b %h exp=1 00000002", rsp1_valid, rsp1_data); else passCnt++;
      end
    end
    totalCnt++; if (got !== 1) $display("FAIL contend_drop_timeout got=%0d exp=1", got); else passCnt++;
    clearInputs();
  endtask

  task automatic test_backpressure;
    int seen;
    doReset();
    req1_valid = 1; req1_A = 32'hFFFF; req1_B = 32'hFFFF; req1_S = 2'b11;
    rsp0_ready = 1;  // wrong port: must be ignored
    #1;
    totalCnt++; if (req1_ready !== 1'b1) $display("FAIL bp_accept got=%b exp=1", req1_ready); else passCnt++;
    @(negedge clk);
    req0_valid = 1; req0_A = $urandom;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk); #1;
      if (rsp1_valid) seen = 1;
    end
    totalCnt++; if (seen !== 1) $display("FAIL bp_timeout got=%0d exp=1", seen); else passCnt++;
    for (int i = 0; i < 5; i++) begin
      totalCnt++; if ({rsp1_valid, rsp1_data} !== {1'b1, 32'h00000003}) $display("FAIL bp_hold i=%0d got=%b %h exp=1 00000003", i, rsp1_valid, rsp1_data); else passCnt++;
      totalCnt++; if ({req0_ready, req1_ready, rsp0_valid} !== 3'b000) $display("FAIL bp_noready i=%0d got=%b%b%b exp=000", i, req0_ready, req1_ready, rsp0_valid); else passCnt++;
      @(negedge clk); #1;
    end
    rsp1_ready = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk); #1;
    totalCnt++; if ({busy, rsp1_valid} !== 2'b00) $display("FAIL bp_release got=%b%b exp=00", busy, rsp1_valid); else passCnt++;
    clearInputs();
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] expData;
    int          seen;
    doReset();
    req0_valid = 1; req0_A = $urandom; req0_B = $urandom; req0_S = 2'($urandom);
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    req0_valid = 0;
    #1;
    totalCnt++; if (busy !== 1'b1) $display("FAIL midrst_exec got=%b exp=1", busy); else passCnt++;
    rst = 1;
    #1;
    totalCnt++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) $display("FAIL midrst_flags got=%b%b%b exp=000", busy, rsp0_valid, rsp1_valid); else passCnt++;
    totalCnt++; if ({lu_A, lu_B, lu_S, rsp0_data, rsp1_data} !== 130'h0) $display("FAIL midrst_regs got=%h %h %h exp=0", lu_A, lu_B, lu_S); else passCnt++;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      totalCnt++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) $display("FAIL midrst_ghost i=%0d got=%b%b%b exp=000", i, rsp0_valid, rsp1_valid, busy); else passCnt++;
    end
    req1_valid = 1; req1_A = $urandom; req1_B = $urandom; req1_S = 2'($urandom);
    expData = req1_A ^ req1_B ^ {30'b0, req1_S};
    @(negedge clk);
    req1_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk); #1;
      if (rsp1_valid) begin
        seen = 1;
        totalCnt++; if (rsp1_data !== expData) $display("FAIL midrst_next_data got=%h exp=%h", rsp1_data, expData); else passCnt++;
      end
    end
    totalCnt++; if (seen !== 1) $display("FAIL midrst_next_timeout got=%0d exp=1", seen); else passCnt++;
    clearInputs();
  endtask

  // Transaction-level model: a pending op accepted at cycle acceptCyc
  // responds from cycle acceptCyc+2 until its requester takes it.
  task automatic test_random;
    logic        pending, pPort, lastServed, win;
    logic [31:0] pData;
    int          acceptCyc;
    logic        expR0, expR1, expV0, expV1;
    logic [31:0] expD0, expD1;
    doReset();
    pending = 0; pPort = 0; pData = '0; acceptCyc = 0; lastServed = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 99) < 60); req1_valid = ($urandom_range(0, 99) < 60);
      req0_A = $urandom; req0_B = $urandom; req0_S = 2'($urandom);
      req1_A = $urandom; req1_B = $urandom; req1_S = 2'($urandom);
      rsp0_ready = ($urandom_range(0, 99) < 70); rsp1_ready = ($urandom_range(0, 99) < 70);
      #1;
      win   = pickWinner(req0_valid, req1_valid, lastServed);
      expR0 = !pending && req0_valid && !win;
      expR1 = !pending && req1_valid && win;
      expV0 = pending && (k >= acceptCyc + 2) && !pPort;
      expV1 = pending && (k >= acceptCyc + 2) && pPort;
      expD0 = expV0 ? pData : 32'h0;
      expD1 = expV1 ? pData : 32'h0;
      totalCnt++; if (req0_ready !== expR0) $display("FAIL rnd_ready0 k=%0d got=%b exp=%b", k, req0_ready, expR0); else passCnt++;
      totalCnt++; if (req1_ready !== expR1) $display("FAIL rnd_ready1 k=%0d got=%b exp=%b", k, req1_ready, expR1); else passCnt++;
      totalCnt++; if (rsp0_valid !== expV0) $display("FAIL rnd_valid0 k=%0d got=%b exp=%b", k, rsp0_valid, expV0); else passCnt++;
      totalCnt++; if (rsp1_valid !== expV1) $display("FAIL rnd_valid1 k=%0d got=%b exp=%b", k, rsp1_valid, expV1); else passCnt++;
      totalCnt++; if (rsp0_data !== expD0) $display("FAIL rnd_data0 k=%0d got=%h exp=%h", k, rsp0_data, expD0); else passCnt++;
      totalCnt++; if (rsp1_data !== expD1) $display("FAIL rnd_data1 k=%0d got=%h exp=%h", k, rsp1_data, expD1); else passCnt++;
      totalCnt++; if (busy !== pending) $display("FAIL rnd_busy k=%0d got=%b exp=%b", k, busy, pending); else passCnt++;
      if ((expV0 && rsp0_ready) || (expV1 && rsp1_ready)) begin
        pending = 0;
        lastServed = pPort;
      end else if (expR0 || expR1) begin
        pending = 1;
        pPort = win;
        pData = win ? (req1_A ^ req1_B ^ {30'b0, req1_S}) : (req0_A ^ req0_B ^ {30'b0, req0_S});
        acceptCyc = k;
      end
    end
    clearInputs();
  endtask

  initial begin
    rst = 1;
    clearInputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
